// File: rtl/pipeline_dmem_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_dmem_ctrl_if : req/ready request and rvalid response data-memory bus
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pipeline_dmem_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata;
  logic            ready;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output ready, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_dmem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_dmem_ctrl : M-stage data-memory controller with lane alignment,
//                      load extension, misalign detection and pipeline stall
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipeline_dmem_ctrl #(
  parameter int XLEN = 32
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst,
  input  wire logic            i_ctrl_mem_wr_enM,
  input  wire logic [1:0]      i_ctrl_result_srcM,
  input  wire logic [3:0]      i_ctrl_mem_byte_selM,
  input  wire logic            i_load_unsignedM,
  input  wire logic [XLEN-1:0] i_alu_resultM,
  input  wire logic [XLEN-1:0] i_mem_writedataM,
  output logic                 o_stallM,
  output logic [XLEN-1:0]      o_readdataM,
  output logic                 o_readdata_validM,
  output logic                 o_misalignM,
  pipeline_dmem_ctrl_if.master dmem
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      off_q, off_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            valid_q, valid_d;
  logic            misalign_q, misalign_d;

  logic            access;
  logic [1:0]      off;
  logic            is_byte, is_half, is_word, misaligned;
  logic [3:0]      be_shifted;
  logic [XLEN-1:0] lane_mask;
  logic [XLEN-1:0] wdata_shifted;
  logic [XLEN-1:0] rdata_lane;
  logic [XLEN-1:0] load_fmt;

  assign access = i_ctrl_mem_wr_enM | (i_ctrl_result_srcM == 2'b01);
  assign off    = i_alu_resultM[1:0];

  always_comb begin
    is_byte       = (i_ctrl_mem_byte_selM == 4'b0001);
    is_half       = (i_ctrl_mem_byte_selM == 4'b0011);
    is_word       = (i_ctrl_mem_byte_selM == 4'b1111);
    misaligned    = ~(is_byte | is_half | is_word) | (is_half & off[0]) |
                    (is_word & (off != 2'b00));
    be_shifted    = i_ctrl_mem_byte_selM << off;
    lane_mask     = {{8{be_shifted[3]}}, {8{be_shifted[2]}},
                     {8{be_shifted[1]}}, {8{be_shifted[0]}}};
    // Unused lanes are forced to zero even if the store data carries upper junk.
    wdata_shifted = (i_mem_writedataM << {off, 3'b000}) & lane_mask;
  end

  always_comb begin
    rdata_lane = dmem.rdata >> {off_q, 3'b000};
    if (is_byte) begin
      load_fmt = {{(XLEN-8){~i_load_unsignedM & rdata_lane[7]}}, rdata_lane[7:0]};
    end else if (is_half) begin
      load_fmt = {{(XLEN-16){~i_load_unsignedM & rdata_lane[15]}}, rdata_lane[15:0]};
    end else begin
      load_fmt = rdata_lane;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    off_d      = off_q;
    rdata_d    = rdata_q;
    valid_d    = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            state_d    = DONE;
            misalign_d = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = i_ctrl_mem_wr_enM;
            addr_d  = {i_alu_resultM[XLEN-1:2], 2'b00};
            be_d    = be_shifted;
            wdata_d = wdata_shifted;
            off_d   = off;
          end
        end
      end
      REQ: begin
        if (dmem.ready) begin
          req_d   = 1'b0;
          state_d = we_q ? DONE : WAIT_R;
        end
      end
      WAIT_R: begin
        if (dmem.rvalid) begin
          rdata_d = load_fmt;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      off_q      <= 2'b00;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      off_q      <= off_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  // Stall drops in DONE so the pipeline advances on the edge leaving DONE.
  assign o_stallM          = access & (state_q != DONE);
  assign o_readdataM       = rdata_q;
  assign o_readdata_validM = valid_q;
  assign o_misalignM       = misalign_q;
  assign dmem.req          = req_q;
  assign dmem.we           = we_q;
  assign dmem.addr         = addr_q;
  assign dmem.be           = be_q;
  assign dmem.wdata        = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_dmem_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipeline_dmem_ctrl : directed vector table plus reset corner sequence
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pipeline_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [1:0]  result_src;
  logic [3:0]  byte_sel;
  logic        load_uns;
  logic [31:0] alu_result;
  logic [31:0] writedata;
  logic        stall;
  logic [31:0] readdata;
  logic        readdata_valid;
  logic        misalign;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_dmem_ctrl_if #(.XLEN(32)) dmem ();

  pipeline_dmem_ctrl #(.XLEN(32)) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_ctrl_mem_wr_enM    (wr_en),
    .i_ctrl_result_srcM   (result_src),
    .i_ctrl_mem_byte_selM (byte_sel),
    .i_load_unsignedM     (load_uns),
    .i_alu_resultM        (alu_result),
    .i_mem_writedataM     (writedata),
    .o_stallM             (stall),
    .o_readdataM          (readdata),
    .o_readdata_validM    (readdata_valid),
    .o_misalignM          (misalign),
    .dmem                 (dmem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  src;
    logic [3:0]  sel;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ready_wait;
    int          rvalid_lat;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    int          e_stall;
    int          e_reqs;
    logic        e_valid;
    logic        e_mis;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop_inputs();
    wr_en       = 1'b0;
    result_src  = 2'b00;
    byte_sel    = 4'b0000;
    load_uns    = 1'b0;
    alu_result  = 32'h0;
    writedata   = 32'h0;
    dmem.ready  = 1'b0;
    dmem.rvalid = 1'b0;
    dmem.rdata  = 32'h0;
  endtask

  task automatic run_vec(input vec_t v);
    int  cycle;
    int  stall_cnt;
    int  req_cnt;
    int  accepted;
    int  pulses;
    bit  done;
    logic done_valid;
    logic done_mis;
    cycle = 0; stall_cnt = 0; req_cnt = 0; accepted = -1; pulses = 0;
    done = 1'b0; done_valid = 1'b0; done_mis = 1'b0;
    @(posedge clk); #1;
    wr_en      = v.we;
    result_src = v.src;
    byte_sel   = v.sel;
    load_uns   = v.uns;
    alu_result = v.addr;
    writedata  = v.wdata;
    dmem.rdata = v.rdata;
    while (!done && cycle < 40) begin
      dmem.ready  = dmem.req && (req_cnt >= v.ready_wait);
      dmem.rvalid = !v.we && (accepted >= 0) && (cycle == accepted + v.rvalid_lat);
      #4;
      if (dmem.req) begin
        req_cnt++;
        chk($sformatf("%s addr", v.name), dmem.addr, v.e_addr);
        chk($sformatf("%s be", v.name), {28'h0, dmem.be}, {28'h0, v.e_be});
        chk($sformatf("%s wdata", v.name), dmem.wdata, v.e_wdata);
        chk($sformatf("%s we", v.name), {31'h0, dmem.we}, {31'h0, v.e_we});
        if (dmem.ready) accepted = cycle;
      end
      if (readdata_valid || misalign) pulses++;
      if (stall) begin
        stall_cnt++;
      end else begin
        done       = 1'b1;
        done_valid = readdata_valid;
        done_mis   = misalign;
      end
      @(posedge clk); #1;
      cycle++;
    end
    drop_inputs();
    chk($sformatf("%s finished", v.name), {31'h0, done}, 32'h1);
    chk($sformatf("%s stall cycles", v.name), stall_cnt, v.e_stall);
    chk($sformatf("%s req cycles", v.name), req_cnt, v.e_reqs);
    chk($sformatf("%s valid in done", v.name), {31'h0, done_valid}, {31'h0, v.e_valid});
    chk($sformatf("%s misalign in done", v.name), {31'h0, done_mis}, {31'h0, v.e_mis});
    chk($sformatf("%s pulse count", v.name), pulses, (v.e_valid || v.e_mis) ? 1 : 0);
    chk($sformatf("%s readdata", v.name), readdata, v.e_rd);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk($sformatf("%s req", tag), {31'h0, dmem.req}, 32'h0);
    chk($sformatf("%s we", tag), {31'h0, dmem.we}, 32'h0);
    chk($sformatf("%s addr", tag), dmem.addr, 32'h0);
    chk($sformatf("%s be", tag), {28'h0, dmem.be}, 32'h0);
    chk($sformatf("%s wdata", tag), dmem.wdata, 32'h0);
    chk($sformatf("%s readdata", tag), readdata, 32'h0);
    chk($sformatf("%s valid", tag), {31'h0, readdata_valid}, 32'h0);
    chk($sformatf("%s misalign", tag), {31'h0, misalign}, 32'h0);
    chk($sformatf("%s stall", tag), {31'h0, stall}, 32'h0);
  endtask

  initial begin
    //          name      we    src    sel     uns   addr          wdata         rw lat rdata          e_addr        e_be     e_wdata       e_we  st rq valid mis  e_rd
    vecs[0]  = '{"sw",     1'b1, 2'b00, 4'hF, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 0, 1, 32'h0,         32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 1'b1, 2, 1, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{"lb",     1'b0, 2'b01, 4'h1, 1'b0, 32'h0000_0203, 32'h0,         0, 1, 32'h80FF_1234, 32'h0000_0200, 4'b1000, 32'h0,         1'b0, 3, 1, 1'b1, 1'b0, 32'hFFFF_FF80};
    vecs[2]  = '{"lhu",    1'b0, 2'b01, 4'h3, 1'b1, 32'h0000_0302, 32'h0,         3, 1, 32'hBEEF_0000, 32'h0000_0300, 4'b1100, 32'h0,         1'b0, 6, 4, 1'b1, 1'b0, 32'h0000_BEEF};
    vecs[3]  = '{"lw_mis", 1'b0, 2'b01, 4'hF, 1'b0, 32'h0000_0401, 32'h0,         0, 1, 32'h0,         32'h0,         4'b0000, 32'h0,         1'b0, 1, 0, 1'b0, 1'b1, 32'h0000_BEEF};
    vecs[4]  = '{"sb",     1'b1, 2'b00, 4'h1, 1'b0, 32'h0000_0003, 32'h0000_00AB, 0, 1, 32'h0,         32'h0,         4'b1000, 32'hAB00_0000, 1'b1, 2, 1, 1'b0, 1'b0, 32'h0000_BEEF};
    vecs[5]  = '{"lh",     1'b0, 2'b01, 4'h3, 1'b0, 32'h0000_0202, 32'h0,         0, 2, 32'h8001_5555, 32'h0000_0200, 4'b1100, 32'h0,         1'b0, 4, 1, 1'b1, 1'b0, 32'hFFFF_8001};
    vecs[6]  = '{"lbu",    1'b0, 2'b01, 4'h1, 1'b1, 32'h0000_0201, 32'h0,         0, 1, 32'h0000_F000, 32'h0000_0200, 4'b0010, 32'h0,         1'b0, 3, 1, 1'b1, 1'b0, 32'h0000_00F0};
    vecs[7]  = '{"sh",     1'b1, 2'b00, 4'h3, 1'b0, 32'h0000_0002, 32'hFFFF_1234, 1, 1, 32'h0,         32'h0,         4'b1100, 32'h1234_0000, 1'b1, 3, 2, 1'b0, 1'b0, 32'h0000_00F0};
    vecs[8]  = '{"bad_sel",1'b0, 2'b01, 4'h7, 1'b0, 32'h0000_0000, 32'h0,         0, 1, 32'h0,         32'h0,         4'b0000, 32'h0,         1'b0, 1, 0, 1'b0, 1'b1, 32'h0000_00F0};
    vecs[9]  = '{"lh_mis", 1'b0, 2'b01, 4'h3, 1'b0, 32'h0000_0001, 32'h0,         0, 1, 32'h0,         32'h0,         4'b0000, 32'h0,         1'b0, 1, 0, 1'b0, 1'b1, 32'h0000_00F0};
    vecs[10] = '{"st_ld",  1'b1, 2'b01, 4'hF, 1'b0, 32'h0000_0008, 32'h55AA_55AA, 0, 1, 32'h0,         32'h0000_0008, 4'b1111, 32'h55AA_55AA, 1'b1, 2, 1, 1'b0, 1'b0, 32'h0000_00F0};
    vecs[11] = '{"lw",     1'b0, 2'b01, 4'hF, 1'b0, 32'h0000_0100, 32'h0,         0, 1, 32'h1234_5678, 32'h0000_0100, 4'b1111, 32'h0,         1'b0, 3, 1, 1'b1, 1'b0, 32'h1234_5678};
    vecs[12] = '{"sw_mis", 1'b1, 2'b00, 4'hF, 1'b0, 32'h0000_0006, 32'h1111_2222, 0, 1, 32'h0,         32'h0,         4'b0000, 32'h0,         1'b0, 1, 0, 1'b0, 1'b1, 32'h1234_5678};
    vecs[13] = '{"sb_lane1",1'b1,2'b00, 4'h1, 1'b0, 32'h0000_0011, 32'hFFFF_FF5A, 0, 1, 32'h0,         32'h0000_0010, 4'b0010, 32'h0000_5A00, 1'b1, 2, 1, 1'b0, 1'b0, 32'h1234_5678};

    rst = 1'b1;
    drop_inputs();
    repeat (2) @(posedge clk);
    #4;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Idle cycle: no access means no stall and no bus request.
    @(posedge clk); #4;
    chk("idle stall", {31'h0, stall}, 32'h0);
    chk("idle req", {31'h0, dmem.req}, 32'h0);

    // Reset while waiting for read data, then a late rvalid in IDLE.
    @(posedge clk); #1;
    wr_en = 1'b0; result_src = 2'b01; byte_sel = 4'hF; load_uns = 1'b0;
    alu_result = 32'h0000_0500; dmem.rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    chk("rst_seq req in REQ", {31'h0, dmem.req}, 32'h1);
    dmem.ready = 1'b1;
    @(posedge clk); #1;
    dmem.ready = 1'b0;
    #3;
    chk("rst_seq stall in WAIT_R", {31'h0, stall}, 32'h1);
    chk("rst_seq req in WAIT_R", {31'h0, dmem.req}, 32'h0);
    @(negedge clk); #1;
    rst = 1'b1;
    wr_en = 1'b0; result_src = 2'b00; byte_sel = 4'h0; alu_result = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem.rvalid = 1'b1;
    #3;
    chk_reset_outputs("after_rst");
    @(posedge clk); #1;
    dmem.rvalid = 1'b0;
    #3;
    chk("late rvalid valid", {31'h0, readdata_valid}, 32'h0);
    chk("late rvalid readdata", readdata, 32'h0);
    chk("late rvalid req", {31'h0, dmem.req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_dmem_ctrl.md
Name: pipeline_dmem_ctrl

Overview:
- Memory-stage data-memory controller for the RV32I pipelined core.
- Consumes the control and data signals held in the EX/MEM register: address from alu_result, store data, write enable, byte select and result source.
- Drives a req/ready request channel and an rvalid response channel to the data memory.
- Returns load data that is lane-aligned and sign- or zero-extended.
- Stalls the pipeline until the access completes.

Parameters:
- XLEN, 32, data and address width (must be 32).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_ctrl_mem_wr_enM  in  1  store in M stage.
- i_ctrl_result_srcM  in  2  2'b01 marks a load.
- i_ctrl_mem_byte_selM  in  4  unshifted size mask: 4'b0001 byte, 4'b0011 half, 4'b1111 word.
- i_load_unsignedM  in  1  1 = zero-extend (LBU/LHU), 0 = sign-extend.
- i_alu_resultM  in  XLEN  byte address.
- i_mem_writedataM  in  XLEN  store data, right-justified.
- o_stallM  out  1  holds IF..M stages.
- o_readdataM  out  XLEN  formatted load data.
- o_readdata_validM  out  1  one-cycle pulse with load result.
- o_misalignM  out  1  one-cycle fault pulse.
- o_dmem_req  out  1  request valid.
- o_dmem_we  out  1  write request.
- o_dmem_addr  out  XLEN  word address, bits [1:0] = 0.
- o_dmem_be  out  4  lane byte enables.
- o_dmem_wdata  out  XLEN  lane-positioned write data.
- i_dmem_ready  in  1  request accepted when req & ready.
- i_dmem_rvalid  in  1  read data valid.
- i_dmem_rdata  in  XLEN  read word.

Behaviour:
- access = i_ctrl_mem_wr_enM | (i_ctrl_result_srcM == 2'b01). If both are set, the access is a store.
- off = addr[1:0].
- Misaligned when any of these holds:
  - half with off[0] = 1;
  - word with off != 0;
  - byte_sel not in {0001, 0011, 1111}.
- State machine: IDLE, REQ, WAIT_R, DONE. The state register is synchronous.
  - IDLE:
    - no access -> stay IDLE.
    - access and misaligned -> DONE with fault flag set; no bus request is issued.
    - access otherwise -> REQ, and latch we, addr & ~3, be = byte_sel << off, wdata = data << (8*off).
    - Byte stores replicate nothing; unused lanes drive 0.
  - REQ:
    - o_dmem_req = 1; address, be, wdata and we are stable until accepted.
    - req & ready with a store -> DONE.
    - req & ready with a load -> WAIT_R.
  - WAIT_R:
    - o_dmem_req = 0.
    - On i_dmem_rvalid, extract the lane at off, extend per size and i_load_unsignedM, register the result into o_readdataM, then -> DONE.
    - rvalid is only sampled in WAIT_R. rvalid in the same cycle as acceptance is not legal for the memory.
  - DONE:
    - o_readdata_validM = 1 for a load, o_misalignM = 1 for a fault; each lasts this cycle only.
    - -> IDLE unconditionally.
- o_stallM (combinational) = access & (state != DONE). It deasserts in DONE so the pipeline advances on that edge. M-stage inputs are stable while stalled.
- Latency:
  - Store with ready in the first REQ cycle: 2 stall cycles.
  - Load with rvalid one cycle after acceptance: 3 stall cycles.
  - Misaligned access: 1 stall cycle.
  - Back-to-back accesses re-enter IDLE between them, so there is no overlap.
- o_readdataM holds its value until the next load completes. A store or a fault does not change it.
- Reset values:
  - state = IDLE;
  - o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata = 0;
  - o_readdataM = 0;
  - valid and misalign pulses = 0.
- Reset mid-operation: the next edge returns to IDLE and drops req. A late rvalid arriving in IDLE is ignored.
- Non-access cycles: stall = 0 and no bus activity.

Test Plan:
1. SW addr 0x104, data 0xDEADBEEF, ready=1 in REQ -> one req cycle with addr 0x104, be 1111, wdata 0xDEADBEEF, we=1; stall for exactly 2 cycles; no readdata_valid pulse.
2. LB addr 0x203, signed, rdata 0x80FF_1234 one cycle after accept -> be 1000, addr 0x200; o_readdataM 0xFFFF_FF80; valid pulse in DONE; 3 stall cycles.
3. LHU addr 0x302, rdata 0xBEEF_0000, ready held low 3 cycles -> req stays high with stable addr 0x300 and be 1100 through the wait; result 0x0000_BEEF.
4. LW addr 0x401 -> no req; o_misalignM pulses after 1 stall cycle; o_readdataM unchanged.
5. Assert i_rst while in WAIT_R, then pulse rvalid -> IDLE on the next edge; req = 0; no valid pulse; all outputs at reset values.
6. SB addr 0x3, data 0x0000_00AB -> be 1000, wdata 0xAB00_0000.
